// File: rtl/nora_mst_arbiter.sv
// ============================================================================
// nora_mst_arbiter : two-master round-robin arbiter in front of the NORA bus
//                    controller (m0 = ICD controller, m1 = second master).
// Optional feature : define NORA_ARB_TIMEOUT_EN to add the ack-wait watchdog.
// Revision         : 1.0
// ============================================================================
`default_nettype none

module nora_mst_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk6x,
  input  logic        reset,
  input  logic [23:0] m0_addr_i,
  input  logic [7:0]  m0_datawr_i,
  input  logic        m0_rwn_i,
  input  logic        m0_req_SRAM_i,
  input  logic        m0_req_OTHER_i,
  input  logic [23:0] m1_addr_i,
  input  logic [7:0]  m1_datawr_i,
  input  logic        m1_rwn_i,
  input  logic        m1_req_SRAM_i,
  input  logic        m1_req_OTHER_i,
  output logic [7:0]  m0_datard_o,
  output logic        m0_ack_o,
  output logic [7:0]  m1_datard_o,
  output logic        m1_ack_o,
  output logic [23:0] nora_mst_addr_o,
  output logic [7:0]  nora_mst_data_o,
  output logic        nora_mst_rwn_o,
  output logic        nora_mst_req_SRAM_o,
  output logic        nora_mst_req_OTHER_o,
  input  logic [7:0]  nora_mst_datard_i,
  input  logic        nora_mst_ack_i,
  output logic [1:0]  grant_o,
  output logic        timeout_o,
  input  logic        timeout_clr_i
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT0  = 2'd1,
    ST_GRANT1  = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_last_grant;  // 0 = m0 served last, 1 = m1 served last
  logic [1:0]  r_grant;
  logic [23:0] r_addr;
  logic [7:0]  r_data;
  logic        r_rwn;
  logic        r_req_sram;
  logic        r_req_other;

  logic w_m0_pend;
  logic w_m1_pend;
  logic w_pick_m1;
  logic w_in_grant;
  logic w_tmo_hit;
  logic w_ack_evt;
  logic w_sel_sram;
  logic w_sel_other;

  assign w_m0_pend  = m0_req_SRAM_i | m0_req_OTHER_i;
  assign w_m1_pend  = m1_req_SRAM_i | m1_req_OTHER_i;
  assign w_pick_m1  = w_m1_pend & (~w_m0_pend | ~r_last_grant);
  assign w_in_grant = (r_state == ST_GRANT0) || (r_state == ST_GRANT1);

  assign w_sel_sram  = w_pick_m1 ? m1_req_SRAM_i  : m0_req_SRAM_i;
  assign w_sel_other = w_pick_m1 ? m1_req_OTHER_i : m0_req_OTHER_i;

`ifdef NORA_ARB_TIMEOUT_EN
  localparam logic [7:0] C_TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] r_wait_cnt;
  logic       r_timeout;

  assign w_tmo_hit = w_in_grant & ~nora_mst_ack_i & (r_wait_cnt == C_TMO_LAST);
  assign timeout_o = r_timeout;

  always_ff @(posedge clk6x) begin
    if (reset) begin
      r_wait_cnt <= 8'd0;
      r_timeout  <= 1'b0;
    end else begin
      if (!w_in_grant)
        r_wait_cnt <= 8'd0;
      else if (!nora_mst_ack_i)
        r_wait_cnt <= r_wait_cnt + 8'd1;
      // A timeout in the same cycle as a clear keeps the flag set
      if (w_tmo_hit)
        r_timeout <= 1'b1;
      else if (timeout_clr_i)
        r_timeout <= 1'b0;
    end
  end
`else
  logic w_unused;

  assign w_tmo_hit = 1'b0;
  assign timeout_o = 1'b0;
  assign w_unused  = timeout_clr_i ^ (TIMEOUT_CYCLES == 0);
`endif

  // Reset wins over a coincident ack so an aborted access never completes
  assign w_ack_evt = w_in_grant & ~reset & (nora_mst_ack_i | w_tmo_hit);

  assign m0_ack_o    = w_ack_evt & (r_state == ST_GRANT0);
  assign m1_ack_o    = w_ack_evt & (r_state == ST_GRANT1);
  assign m0_datard_o = m0_ack_o ? (nora_mst_ack_i ? nora_mst_datard_i : 8'hFF) : 8'h00;
  assign m1_datard_o = m1_ack_o ? (nora_mst_ack_i ? nora_mst_datard_i : 8'hFF) : 8'h00;

  assign grant_o              = r_grant;
  assign nora_mst_addr_o      = r_addr;
  assign nora_mst_data_o      = r_data;
  assign nora_mst_rwn_o       = r_rwn;
  assign nora_mst_req_SRAM_o  = r_req_sram;
  assign nora_mst_req_OTHER_o = r_req_other;

  always_ff @(posedge clk6x) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_grant      <= 2'b00;
      r_addr       <= 24'd0;
      r_data       <= 8'd0;
      r_rwn        <= 1'b0;
      r_req_sram   <= 1'b0;
      r_req_other  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_m0_pend || w_m1_pend) begin
            r_state     <= w_pick_m1 ? ST_GRANT1 : ST_GRANT0;
            r_grant     <= w_pick_m1 ? 2'b10 : 2'b01;
            r_addr      <= w_pick_m1 ? m1_addr_i   : m0_addr_i;
            r_data      <= w_pick_m1 ? m1_datawr_i : m0_datawr_i;
            r_rwn       <= w_pick_m1 ? m1_rwn_i    : m0_rwn_i;
            r_req_sram  <= w_sel_sram;
            r_req_other <= w_sel_other & ~w_sel_sram;
          end
        end
        ST_GRANT0, ST_GRANT1: begin
          if (w_ack_evt) begin
            r_state      <= ST_RELEASE;
            r_grant      <= 2'b00;
            r_req_sram   <= 1'b0;
            r_req_other  <= 1'b0;
            r_last_grant <= (r_state == ST_GRANT1);
          end
        end
        ST_RELEASE: r_state <= ST_IDLE;
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_nora_mst_arbiter.sv
// ============================================================================
// tb_nora_mst_arbiter : directed self-checking bench for nora_mst_arbiter.
// Revision            : 1.0
// ============================================================================
`default_nettype none

module tb_nora_mst_arbiter;

  localparam int unsigned TMO = 8;

  logic        clk6x = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] m0_addr_i = '0, m1_addr_i = '0;
  logic [7:0]  m0_datawr_i = '0, m1_datawr_i = '0;
  logic        m0_rwn_i = 1'b1, m1_rwn_i = 1'b1;
  logic        m0_req_SRAM_i = 1'b0, m0_req_OTHER_i = 1'b0;
  logic        m1_req_SRAM_i = 1'b0, m1_req_OTHER_i = 1'b0;
  logic [7:0]  m0_datard_o, m1_datard_o;
  logic        m0_ack_o, m1_ack_o;
  logic [23:0] nora_mst_addr_o;
  logic [7:0]  nora_mst_data_o;
  logic        nora_mst_rwn_o, nora_mst_req_SRAM_o, nora_mst_req_OTHER_o;
  logic [7:0]  nora_mst_datard_i = '0;
  logic        nora_mst_ack_i = 1'b0;
  logic [1:0]  grant_o;
  logic        timeout_o;
  logic        timeout_clr_i = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  nora_mst_arbiter #(.TIMEOUT_CYCLES(TMO)) u_dut (
    .clk6x               (clk6x),
    .reset               (reset),
    .m0_addr_i           (m0_addr_i),
    .m0_datawr_i         (m0_datawr_i),
    .m0_rwn_i            (m0_rwn_i),
    .m0_req_SRAM_i       (m0_req_SRAM_i),
    .m0_req_OTHER_i      (m0_req_OTHER_i),
    .m1_addr_i           (m1_addr_i),
    .m1_datawr_i         (m1_datawr_i),
    .m1_rwn_i            (m1_rwn_i),
    .m1_req_SRAM_i       (m1_req_SRAM_i),
    .m1_req_OTHER_i      (m1_req_OTHER_i),
    .m0_datard_o         (m0_datard_o),
    .m0_ack_o            (m0_ack_o),
    .m1_datard_o         (m1_datard_o),
    .m1_ack_o            (m1_ack_o),
    .nora_mst_addr_o     (nora_mst_addr_o),
    .nora_mst_data_o     (nora_mst_data_o),
    .nora_mst_rwn_o      (nora_mst_rwn_o),
    .nora_mst_req_SRAM_o (nora_mst_req_SRAM_o),
    .nora_mst_req_OTHER_o(nora_mst_req_OTHER_o),
    .nora_mst_datard_i   (nora_mst_datard_i),
    .nora_mst_ack_i      (nora_mst_ack_i),
    .grant_o             (grant_o),
    .timeout_o           (timeout_o),
    .timeout_clr_i       (timeout_clr_i)
  );

  always #5 clk6x = ~clk6x;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too
  task automatic tick();
    @(posedge clk6x);
    #1;
  endtask

  task automatic ack_now(input logic [7:0] d);
    nora_mst_ack_i    = 1'b1;
    nora_mst_datard_i = d;
    #1;
  endtask

  task automatic ack_clear();
    nora_mst_ack_i    = 1'b0;
    nora_mst_datard_i = 8'h00;
  endtask

  initial begin
    tick(); tick(); tick();
    check_val("rst_grant", grant_o, 2'b00);
    check_val("rst_req", {nora_mst_req_SRAM_o, nora_mst_req_OTHER_o}, 2'b00);
    check_val("rst_addr", nora_mst_addr_o, 24'h0);
    check_val("rst_acks", {m0_ack_o, m1_ack_o}, 2'b00);
    check_val("rst_tmo", timeout_o, 1'b0);
    reset = 1'b0;
    tick();

    // m0 read from SRAM, downstream acks in the 4th grant cycle
    m0_addr_i = 24'h012345; m0_rwn_i = 1'b1; m0_req_SRAM_i = 1'b1;
    m1_addr_i = 24'hABCDEF;
    check_val("s1_idle_req", nora_mst_req_SRAM_o, 1'b0);
    tick();
    check_val("s1_grant", grant_o, 2'b01);
    check_val("s1_req_sram", nora_mst_req_SRAM_o, 1'b1);
    check_val("s1_addr", nora_mst_addr_o, 24'h012345);
    check_val("s1_rwn", nora_mst_rwn_o, 1'b1);
    tick(); tick(); tick();
    check_val("s1_no_early_ack", m0_ack_o, 1'b0);
    ack_now(8'hA5);
    check_val("s1_ack", m0_ack_o, 1'b1);
    check_val("s1_rdata", m0_datard_o, 8'hA5);
    check_val("s1_m1_noack", m1_ack_o, 1'b0);
    m0_req_SRAM_i = 1'b0;
    tick(); ack_clear();
    check_val("s1_rel_grant", grant_o, 2'b00);
    check_val("s1_rel_req", nora_mst_req_SRAM_o, 1'b0);
    check_val("s1_rel_ack", m0_ack_o, 1'b0);
    #1;
    check_val("s1_rdata_zero", m0_datard_o, 8'h00);
    tick();

    // Tie after reset: m0 first, then m1; repeated tie after m0 served goes to m1
    reset = 1'b1; tick(); reset = 1'b0;
    m0_req_SRAM_i = 1'b1; m1_req_SRAM_i = 1'b1;
    tick();
    check_val("s2_first", grant_o, 2'b01);
    ack_now(8'h11);
    check_val("s2_ack0", {m0_ack_o, m1_ack_o}, 2'b10);
    m0_req_SRAM_i = 1'b0;
    tick(); ack_clear();
    tick();
    check_val("s2_idle", grant_o, 2'b00);
    tick();
    check_val("s2_second", grant_o, 2'b10);
    ack_now(8'h22);
    check_val("s2_ack1", {m0_ack_o, m1_ack_o}, 2'b01);
    check_val("s2_rdata1", m1_datard_o, 8'h22);
    check_val("s2_rdata0", m0_datard_o, 8'h00);
    m0_req_SRAM_i = 1'b1;
    tick(); ack_clear(); tick(); tick();
    check_val("s2_tie_rr_m0", grant_o, 2'b01);
    ack_now(8'h33);
    tick(); ack_clear(); tick(); tick();
    check_val("s2_tie_rr_m1", grant_o, 2'b10);
    ack_now(8'h44);
    m0_req_SRAM_i = 1'b0; m1_req_SRAM_i = 1'b0;
    tick(); ack_clear(); tick();

    // m1 write with both request bits: only SRAM forwarded, inputs not re-sampled
    m1_addr_i = 24'h00FF00; m1_datawr_i = 8'h3C; m1_rwn_i = 1'b0;
    m1_req_SRAM_i = 1'b1; m1_req_OTHER_i = 1'b1;
    tick();
    check_val("s3_grant", grant_o, 2'b10);
    check_val("s3_reqs", {nora_mst_req_SRAM_o, nora_mst_req_OTHER_o}, 2'b10);
    check_val("s3_rwn", nora_mst_rwn_o, 1'b0);
    check_val("s3_data", nora_mst_data_o, 8'h3C);
    m1_addr_i = 24'h111111; m1_datawr_i = 8'h99;
    tick();
    check_val("s3_addr_hold", nora_mst_addr_o, 24'h00FF00);
    check_val("s3_data_hold", nora_mst_data_o, 8'h3C);
    ack_now(8'h77);
    check_val("s3_ack", {m0_ack_o, m1_ack_o}, 2'b01);
    m1_req_SRAM_i = 1'b0; m1_req_OTHER_i = 1'b0;
    tick();
    // Ack kept high through RELEASE and IDLE must be ignored
    check_val("s4_rel_spur", {m0_ack_o, m1_ack_o}, 2'b00);
    tick();
    check_val("s4_idle_spur", {m0_ack_o, m1_ack_o}, 2'b00);
    tick();
    check_val("s4_idle_stay", grant_o, 2'b00);
    check_val("s4_idle_req", nora_mst_req_SRAM_o, 1'b0);
    ack_clear();

    // Reset two cycles into GRANT0 together with a downstream ack
    m0_addr_i = 24'h000ABC; m0_req_OTHER_i = 1'b1;
    tick(); tick();
    check_val("s5_granted", grant_o, 2'b01);
    check_val("s5_other", nora_mst_req_OTHER_o, 1'b1);
    reset = 1'b1; nora_mst_ack_i = 1'b1;
    #1;
    check_val("s5_no_ack", m0_ack_o, 1'b0);
    tick();
    reset = 1'b0; ack_clear();
    check_val("s5_grant0", grant_o, 2'b00);
    check_val("s5_outs0", {nora_mst_addr_o, nora_mst_req_SRAM_o, nora_mst_req_OTHER_o}, 26'h0);
    m0_req_OTHER_i = 1'b0; m0_req_SRAM_i = 1'b1; m1_req_SRAM_i = 1'b1;
    tick();
    check_val("s5_tie_m0", grant_o, 2'b01);
    ack_now(8'h55);
    m0_req_SRAM_i = 1'b0; m1_req_SRAM_i = 1'b0;
    tick(); ack_clear(); tick();

`ifdef NORA_ARB_TIMEOUT_EN
    // No downstream ack: watchdog acks with FF in the 8th grant cycle
    m0_req_SRAM_i = 1'b1;
    tick();
    for (int i = 1; i < int'(TMO); i++) begin
      check_val("s6_wait_noack", m0_ack_o, 1'b0);
      tick();
    end
    check_val("s6_tmo_ack", m0_ack_o, 1'b1);
    check_val("s6_tmo_data", m0_datard_o, 8'hFF);
    check_val("s6_tmo_pre", timeout_o, 1'b0);
    m0_req_SRAM_i = 1'b0;
    tick();
    check_val("s6_tmo_set", timeout_o, 1'b1);
    check_val("s6_rel", grant_o, 2'b00);
    tick(); tick();
    check_val("s6_tmo_sticky", timeout_o, 1'b1);
    timeout_clr_i = 1'b1;
    tick();
    timeout_clr_i = 1'b0;
    check_val("s6_tmo_clr", timeout_o, 1'b0);
`else
    // No watchdog: the grant is held indefinitely
    m1_req_SRAM_i = 1'b1;
    tick();
    timeout_clr_i = 1'b1;
    for (int i = 0; i < 1000; i++) tick();
    timeout_clr_i = 1'b0;
    check_val("s6_hold_grant", grant_o, 2'b10);
    check_val("s6_hold_req", nora_mst_req_SRAM_o, 1'b1);
    check_val("s6_no_tmo", timeout_o, 1'b0);
    check_val("s6_no_ack", m1_ack_o, 1'b0);
    ack_now(8'h66);
    check_val("s6_late_ack", m1_datard_o, 8'h66);
    m1_req_SRAM_i = 1'b0;
    tick(); ack_clear();
    check_val("s6_rel", grant_o, 2'b00);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
